// File: rtl/mult_issue_ctrl.sv
// Request FIFO and single-outstanding issue controller in front of the cv32e40p multiplier.
// Optional perf counters are built only when MULT_ISSUE_PERF_EN is defined.
module mult_issue_ctrl #(
   parameter int DEPTH = 4,
   parameter int TAG_W = 4
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              flush_i,
   input  logic              req_valid_i,
   output logic              req_ready_o,
   input  logic [1:0]        req_op_i,
   input  logic [31:0]       req_a_i,
   input  logic [31:0]       req_b_i,
   input  logic [TAG_W-1:0]  req_tag_i,
   output logic              mul_enable_o,
   output logic              mul_ex_ready_o,
   output logic [2:0]        mul_operator_o,
   output logic [1:0]        mul_short_signed_o,
   output logic [31:0]       mul_op_a_o,
   output logic [31:0]       mul_op_b_o,
   input  logic [31:0]       mul_result_i,
   input  logic              mul_ready_i,
   output logic              rsp_valid_o,
   input  logic              rsp_ready_i,
   output logic [31:0]       rsp_result_o,
   output logic [TAG_W-1:0]  rsp_tag_o,
   output logic [31:0]       perf_ops_o,
   output logic [31:0]       perf_busy_o
);

   localparam int PTR_W = $clog2(DEPTH);
   localparam logic [PTR_W:0] FULL = (PTR_W+1)'(DEPTH);
   // cv32e40p mul_opcode_e encodings
   localparam logic [2:0] MUL_MAC32 = 3'b000;
   localparam logic [2:0] MUL_H     = 3'b110;

   typedef enum logic {IDLE, ISSUE} state_t;

   state_t state, state_nxt;

   logic [1:0]        fifo_op  [DEPTH];
   logic [31:0]       fifo_a   [DEPTH];
   logic [31:0]       fifo_b   [DEPTH];
   logic [TAG_W-1:0]  fifo_tag [DEPTH];
   logic [PTR_W-1:0]  wr_ptr, rd_ptr;
   logic [PTR_W:0]    count;

   logic              push, pop, capture, discard;
   logic [2:0]        opr_p1;
   logic [1:0]        ss_p1;
   logic [31:0]       a_p1, b_p1;
   logic [TAG_W-1:0]  tag_p1;
   logic              vld_p2;
   logic [31:0]       res_p2;
   logic [TAG_W-1:0]  tag_p2;

   assign req_ready_o = !rst && (count != FULL);
   assign push        = req_valid_i && req_ready_o && !flush_i;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= state_nxt;
      end
   end

   always_comb begin
      state_nxt = state;
      pop       = 1'b0;
      capture   = 1'b0;
      case (state)
         IDLE: begin
            if ((count != '0) && (!vld_p2 || rsp_ready_i) && !flush_i) begin
               pop       = 1'b1;
               state_nxt = ISSUE;
            end
         end
         ISSUE: begin
            if (mul_ready_i) begin
               capture   = 1'b1;
               state_nxt = IDLE;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (push) begin
         fifo_op[wr_ptr]  <= req_op_i;
         fifo_a[wr_ptr]   <= req_a_i;
         fifo_b[wr_ptr]   <= req_b_i;
         fifo_tag[wr_ptr] <= req_tag_i;
      end
   end

   // Flush wins over push/pop: the queue restarts empty at that edge.
   always_ff @(posedge clk) begin
      if (rst || flush_i) begin
         wr_ptr <= '0;
         rd_ptr <= '0;
         count  <= '0;
      end else begin
         if (push) wr_ptr <= wr_ptr + 1'b1;
         if (pop)  rd_ptr <= rd_ptr + 1'b1;
         case ({push, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // ---- issue stage: operands decoded at pop and held for the whole op ----
   always_ff @(posedge clk) begin
      if (rst) begin
         opr_p1 <= MUL_MAC32;
         ss_p1  <= 2'b00;
         a_p1   <= '0;
         b_p1   <= '0;
         tag_p1 <= '0;
      end else if (pop) begin
         a_p1   <= fifo_a[rd_ptr];
         b_p1   <= fifo_b[rd_ptr];
         tag_p1 <= fifo_tag[rd_ptr];
         case (fifo_op[rd_ptr])
            2'b00:   begin opr_p1 <= MUL_MAC32; ss_p1 <= 2'b00; end
            2'b01:   begin opr_p1 <= MUL_H;     ss_p1 <= 2'b11; end
            2'b10:   begin opr_p1 <= MUL_H;     ss_p1 <= 2'b01; end
            default: begin opr_p1 <= MUL_H;     ss_p1 <= 2'b00; end
         endcase
      end
   end

   // Remembers that the in-flight op was flushed so its result is dropped.
   always_ff @(posedge clk) begin
      if (rst || capture) begin
         discard <= 1'b0;
      end else if (flush_i && (state == ISSUE)) begin
         discard <= 1'b1;
      end
   end

   // ---- response stage ----
   always_ff @(posedge clk) begin
      if (rst) begin
         vld_p2 <= 1'b0;
         res_p2 <= '0;
         tag_p2 <= '0;
      end else if (capture && !flush_i && !discard) begin
         vld_p2 <= 1'b1;
         res_p2 <= mul_result_i;
         tag_p2 <= tag_p1;
      end else if (flush_i || (vld_p2 && rsp_ready_i)) begin
         vld_p2 <= 1'b0;
         res_p2 <= '0;
         tag_p2 <= '0;
      end
   end

   assign mul_enable_o       = (state == ISSUE);
   assign mul_ex_ready_o     = (state == ISSUE);
   assign mul_operator_o     = opr_p1;
   assign mul_short_signed_o = ss_p1;
   assign mul_op_a_o         = a_p1;
   assign mul_op_b_o         = b_p1;
   assign rsp_valid_o        = vld_p2;
   assign rsp_result_o       = res_p2;
   assign rsp_tag_o          = tag_p2;

`ifdef MULT_ISSUE_PERF_EN
   logic [31:0] ops_cnt, busy_cnt;

   always_ff @(posedge clk) begin
      if (rst) begin
         ops_cnt  <= '0;
         busy_cnt <= '0;
      end else begin
         if (capture)          ops_cnt  <= ops_cnt + 1'b1;
         if (state == ISSUE)   busy_cnt <= busy_cnt + 1'b1;
      end
   end

   assign perf_ops_o  = ops_cnt;
   assign perf_busy_o = busy_cnt;
`else
   assign perf_ops_o  = '0;
   assign perf_busy_o = '0;
`endif

endmodule

// File: tb/tb_mult_issue_ctrl.sv
// Randomised bench for mult_issue_ctrl with a multiplier stand-in and a queue-based result model.
module tb_mult_issue_ctrl;
   localparam int DEPTH = 4;
   localparam int TAG_W = 4;

   logic              clk = 1'b0;
   logic              rst, flush_i, req_valid_i, req_ready_o;
   logic [1:0]        req_op_i;
   logic [31:0]       req_a_i, req_b_i;
   logic [TAG_W-1:0]  req_tag_i;
   logic              mul_enable_o, mul_ex_ready_o;
   logic [2:0]        mul_operator_o;
   logic [1:0]        mul_short_signed_o;
   logic [31:0]       mul_op_a_o, mul_op_b_o, mul_result_i;
   logic              mul_ready_i;
   logic              rsp_valid_o, rsp_ready_i;
   logic [31:0]       rsp_result_o;
   logic [TAG_W-1:0]  rsp_tag_o;
   logic [31:0]       perf_ops_o, perf_busy_o;

   always #5 clk = ~clk;

   mult_issue_ctrl #(.DEPTH(DEPTH), .TAG_W(TAG_W)) dut (
      .clk(clk), .rst(rst), .flush_i(flush_i),
      .req_valid_i(req_valid_i), .req_ready_o(req_ready_o), .req_op_i(req_op_i),
      .req_a_i(req_a_i), .req_b_i(req_b_i), .req_tag_i(req_tag_i),
      .mul_enable_o(mul_enable_o), .mul_ex_ready_o(mul_ex_ready_o),
      .mul_operator_o(mul_operator_o), .mul_short_signed_o(mul_short_signed_o),
      .mul_op_a_o(mul_op_a_o), .mul_op_b_o(mul_op_b_o),
      .mul_result_i(mul_result_i), .mul_ready_i(mul_ready_i),
      .rsp_valid_o(rsp_valid_o), .rsp_ready_i(rsp_ready_i),
      .rsp_result_o(rsp_result_o), .rsp_tag_o(rsp_tag_o),
      .perf_ops_o(perf_ops_o), .perf_busy_o(perf_busy_o)
   );

   int errors = 0;
   int checks = 0;

   typedef struct packed {
      logic [31:0]      res;
      logic [TAG_W-1:0] tag;
   } exp_t;
   exp_t exp_q[$];

   int busy_seen = 0;
   int ops_seen  = 0;
   int mh_fixed  = -1;

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   // Result of the architectural RISC-V M instruction, from the request opcode.
   function automatic logic [31:0] ref_mul(input logic [1:0] op, input logic [31:0] a,
                                           input logic [31:0] b);
      longint sa, sb, ua, ub;
      logic [63:0] p;
      sa = longint'($signed(a));
      sb = longint'($signed(b));
      ua = longint'({32'h0, a});
      ub = longint'({32'h0, b});
      case (op)
         2'd0:    return a * b;
         2'd1:    p = sa * sb;
         2'd2:    p = sa * ub;
         default: p = ua * ub;
      endcase
      return p[63:32];
   endfunction

   function automatic logic [31:0] env_mult(input logic [2:0] opr, input logic [1:0] ss,
                                            input logic [31:0] a, input logic [31:0] b);
      logic [63:0] ea, eb, p;
      ea = {{32{ss[0] & a[31]}}, a};
      eb = {{32{ss[1] & b[31]}}, b};
      p  = ea * eb;
      return (opr == 3'b000) ? p[31:0] : p[63:32];
   endfunction

   // Multiplier stand-in: MUL answers in the enable cycle, MUL_H after extra cycles.
   initial begin
      int  left;
      bit  prev_en;
      left = 0;
      prev_en = 1'b0;
      mul_ready_i  = 1'b0;
      mul_result_i = '0;
      forever begin
         @(posedge clk);
         #2;
         mul_ready_i  = 1'b0;
         mul_result_i = $urandom;
         if (mul_enable_o) begin
            if (mul_operator_o == 3'b000) begin
               mul_ready_i  = 1'b1;
               mul_result_i = env_mult(mul_operator_o, mul_short_signed_o, mul_op_a_o, mul_op_b_o);
            end else begin
               if (!prev_en) left = (mh_fixed >= 0) ? mh_fixed : int'($urandom_range(0, 4));
               if (left == 0) begin
                  mul_ready_i  = 1'b1;
                  mul_result_i = env_mult(mul_operator_o, mul_short_signed_o, mul_op_a_o, mul_op_b_o);
               end else begin
                  left--;
               end
            end
         end
         prev_en = mul_enable_o;
      end
   end

   // Per-cycle compare: response order/content, held data stability, legal decode.
   logic [2:0]       s_opr;
   logic [1:0]       s_ss;
   logic [31:0]      s_a, s_b, h_res;
   logic [TAG_W-1:0] h_tag;
   bit               en_prev = 1'b0;
   bit               hold    = 1'b0;

   always @(negedge clk) begin
      exp_t e;
      if (rst) begin
         exp_q.delete();
         en_prev   = 1'b0;
         hold      = 1'b0;
         busy_seen = 0;
         ops_seen  = 0;
      end else begin
         if (mul_enable_o) begin
            busy_seen++;
            if (mul_ready_i) ops_seen++;
            chk("decode_legal", ((mul_operator_o == 3'b000) && (mul_short_signed_o == 2'b00)) ||
                                (mul_operator_o == 3'b110), 1);
            chk("ex_ready", mul_ex_ready_o, 1);
            if (en_prev) chk("issue_stable", {mul_operator_o, mul_short_signed_o, mul_op_a_o, mul_op_b_o},
                             {s_opr, s_ss, s_a, s_b});
            s_opr = mul_operator_o;
            s_ss  = mul_short_signed_o;
            s_a   = mul_op_a_o;
            s_b   = mul_op_b_o;
         end
         en_prev = mul_enable_o;
         if (hold && rsp_valid_o) chk("rsp_hold", {rsp_result_o, rsp_tag_o}, {h_res, h_tag});
         hold  = rsp_valid_o && !rsp_ready_i && !flush_i;
         h_res = rsp_result_o;
         h_tag = rsp_tag_o;
         if (rsp_valid_o && rsp_ready_i && !flush_i) begin
            if (exp_q.size() == 0) begin
               chk("spurious_rsp", {rsp_result_o, rsp_tag_o}, 0);
            end else begin
               e = exp_q.pop_front();
               chk("rsp_result", rsp_result_o, e.res);
               chk("rsp_tag", rsp_tag_o, e.tag);
            end
         end
         if (req_valid_i && req_ready_o && !flush_i)
            exp_q.push_back('{res: ref_mul(req_op_i, req_a_i, req_b_i), tag: req_tag_i});
         if (flush_i) exp_q.delete();
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [TAG_W-1:0] tag);
      bit got;
      int n;
      got = 1'b0;
      n = 0;
      req_valid_i = 1'b1;
      req_op_i = op; req_a_i = a; req_b_i = b; req_tag_i = tag;
      while (!got && n < 100) begin
         @(negedge clk);
         got = req_ready_o;
         @(posedge clk);
         #1;
         n++;
      end
      if (!got) chk("send_timeout", 0, 1);
      req_valid_i = 1'b0;
   endtask

   task automatic run_one(input string name, input logic [1:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [TAG_W-1:0] tag,
                          input logic [2:0] e_opr, input logic [1:0] e_ss, input logic [31:0] e_res);
      int n;
      send(op, a, b, tag);
      n = 0;
      @(negedge clk);
      while (!mul_enable_o && n < 50) begin @(negedge clk); n++; end
      chk({name, "_enable"}, mul_enable_o, 1);
      chk({name, "_operator"}, mul_operator_o, e_opr);
      chk({name, "_ss"}, mul_short_signed_o, e_ss);
      n = 0;
      while (!rsp_valid_o && n < 50) begin @(negedge clk); n++; end
      chk({name, "_valid"}, rsp_valid_o, 1);
      chk({name, "_result"}, rsp_result_o, e_res);
      chk({name, "_tag"}, rsp_tag_o, tag);
      @(posedge clk);
      #1;
   endtask

   task automatic drain(input string name);
      int n;
      n = 0;
      while ((exp_q.size() != 0 || rsp_valid_o || mul_enable_o) && n < 300) begin
         @(posedge clk); #1; n++;
      end
      chk(name, exp_q.size(), 0);
   endtask

   function automatic logic [31:0] pick_operand();
      case ($urandom_range(0, 7))
         0:       return 32'h0000_0000;
         1:       return 32'hFFFF_FFFF;
         2:       return 32'h8000_0000;
         3:       return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   initial begin
      #1_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      bit acc, seen;
      rst = 1'b1; flush_i = 1'b0; req_valid_i = 1'b0; rsp_ready_i = 1'b0;
      req_op_i = '0; req_a_i = '0; req_b_i = '0; req_tag_i = '0;

      // reset state
      cyc(2);
      @(negedge clk);
      chk("rst_req_ready", req_ready_o, 0);
      chk("rst_rsp_valid", rsp_valid_o, 0);
      chk("rst_enable", mul_enable_o, 0);
      chk("rst_operands", {mul_op_a_o, mul_op_b_o}, 0);
      chk("rst_perf", {perf_ops_o, perf_busy_o}, 0);
      @(posedge clk); #1;
      rst = 1'b0;
      @(negedge clk);
      chk("post_rst_req_ready", req_ready_o, 1);
      @(posedge clk); #1;

      // MUL latency: handshake E0, issue E1, response after E2
      rsp_ready_i = 1'b1;
      send(2'd0, 32'd7, 32'd6, 4'd3);
      @(negedge clk);
      chk("lat_e0_valid", rsp_valid_o, 0);
      chk("lat_e0_enable", mul_enable_o, 0);
      @(negedge clk);
      chk("lat_e1_enable", mul_enable_o, 1);
      chk("lat_e1_operator", mul_operator_o, 3'b000);
      chk("lat_e1_ss", mul_short_signed_o, 2'b00);
      chk("lat_e1_ops", {mul_op_a_o, mul_op_b_o}, {32'd7, 32'd6});
      @(negedge clk);
      chk("lat_e2_valid", rsp_valid_o, 1);
      chk("lat_e2_result", rsp_result_o, 32'd42);
      chk("lat_e2_tag", rsp_tag_o, 4'd3);
      @(posedge clk); #1;

      run_one("mulh", 2'd1, 32'h8000_0000, 32'h8000_0000, 4'd5, 3'b110, 2'b11, 32'h4000_0000);
      run_one("mulhu", 2'd3, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd6, 3'b110, 2'b00, 32'hFFFF_FFFE);
      run_one("mulhsu", 2'd2, 32'hFFFF_FFFF, 32'd2, 4'd7, 3'b110, 2'b01, 32'hFFFF_FFFF);

      // FIFO fill with a stalled response port
      rsp_ready_i = 1'b0;
      for (int i = 1; i <= 5; i++) send(2'd0, 32'(i), 32'd100, 4'(i));
      cyc(3);
      @(negedge clk);
      chk("full_req_ready", req_ready_o, 0);
      chk("full_rsp_valid", rsp_valid_o, 1);
      chk("full_rsp_tag", rsp_tag_o, 4'd1);
      chk("full_rsp_result", rsp_result_o, 32'd100);
      @(posedge clk); #1;
      rsp_ready_i = 1'b1;
      drain("full_drain");
      @(negedge clk);
      chk("full_ready_again", req_ready_o, 1);
      @(posedge clk); #1;

      // flush during a long MULH with two requests queued
      mh_fixed = 8;
      send(2'd1, 32'd3, 32'd5, 4'd8);
      send(2'd0, 32'd9, 32'd9, 4'd9);
      send(2'd0, 32'd10, 32'd10, 4'd10);
      rsp_ready_i = 1'b0;
      flush_i = 1'b1;
      @(posedge clk); #1;
      flush_i = 1'b0;
      rsp_ready_i = 1'b1;
      @(negedge clk);
      chk("flush_enable_held", mul_enable_o, 1);
      for (int n = 0; n < 30 && mul_enable_o; n++) @(negedge clk);
      chk("flush_enable_drop", mul_enable_o, 0);
      seen = 1'b0;
      repeat (8) begin
         @(negedge clk);
         if (rsp_valid_o || mul_enable_o) seen = 1'b1;
      end
      chk("flush_no_activity", seen, 0);
      @(posedge clk); #1;
      mh_fixed = -1;
      run_one("post_flush", 2'd0, 32'd11, 32'd3, 4'd12, 3'b000, 2'b00, 32'd33);

      // randomized traffic
      for (int c = 0; c < 3000; c++) begin
         @(negedge clk);
         acc = req_valid_i && req_ready_o && !flush_i;
         @(posedge clk); #1;
         if (!req_valid_i || acc) begin
            req_valid_i = ($urandom_range(0, 3) != 0);
            req_op_i    = 2'($urandom_range(0, 3));
            req_a_i     = pick_operand();
            req_b_i     = pick_operand();
            req_tag_i   = 4'($urandom);
         end
         rsp_ready_i = ($urandom_range(0, 3) != 0);
         flush_i = ($urandom_range(0, 149) == 0);
         if (flush_i) rsp_ready_i = 1'b0;
      end
      req_valid_i = 1'b0;
      flush_i = 1'b0;
      rsp_ready_i = 1'b1;
      drain("random_drain");

      // reset in the middle of a MULH abandons it
      mh_fixed = 8;
      send(2'd1, 32'd1234, 32'd5678, 4'd2);
      cyc(3);
      rst = 1'b1;
      cyc(1);
      rst = 1'b0;
      seen = 1'b0;
      repeat (10) begin
         @(negedge clk);
         if (rsp_valid_o || mul_enable_o) seen = 1'b1;
      end
      chk("midop_reset_quiet", seen, 0);
      @(posedge clk); #1;

      // perf counters: 3 MUL + 1 MULH
      mh_fixed = 2;
      run_one("perf_mul0", 2'd0, 32'd2, 32'd3, 4'd1, 3'b000, 2'b00, 32'd6);
      run_one("perf_mul1", 2'd0, 32'd4, 32'd5, 4'd2, 3'b000, 2'b00, 32'd20);
      run_one("perf_mul2", 2'd0, 32'd6, 32'd7, 4'd3, 3'b000, 2'b00, 32'd42);
      run_one("perf_mulh", 2'd3, 32'hFFFF_FFFF, 32'd16, 4'd4, 3'b110, 2'b00, 32'h0000_000F);
      cyc(3);
      @(negedge clk);
`ifdef MULT_ISSUE_PERF_EN
      chk("perf_ops", perf_ops_o, 32'd4);
      chk("perf_busy_total", perf_busy_o, 32'd6);
      chk("perf_busy_seen", perf_busy_o, 32'(busy_seen));
`else
      chk("perf_ops_zero", perf_ops_o, 0);
      chk("perf_busy_zero", perf_busy_o, 0);
`endif
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
